// File: rtl/mire_multi_if.sv
// Wishbone write-master bus between the test-pattern generator and the arbiter.
interface mire_multi_if;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic        we;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        cyc;
  logic        stb;
  logic        ack;

  modport master (
    output adr, dat_ms, we, sel, cti, bte, cyc, stb,
    input  ack
  );

  modport slave (
    input  adr, dat_ms, we, sel, cti, bte, cyc, stb,
    output ack
  );
endinterface

// File: rtl/mire_multi.sv
// Wishbone test-pattern master: fills a framebuffer with grid, checker, bars or solid colour.
module mire_multi #(
  parameter int unsigned HDISP     = 800,
  parameter int unsigned VDISP     = 480,
  parameter logic [31:0] BASE_ADR  = 32'h0,
  parameter int unsigned CELL_LOG2 = 4,
  parameter int unsigned BURST_LEN = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [23:0]         color_fg,
  input  logic [23:0]         color_bg,
  mire_multi_if.master        wshb,
  output logic                busy,
  output logic                frame_done
);

  localparam int unsigned XW    = $clog2(HDISP);
  localparam int unsigned YW    = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int unsigned BW    = HDISP / 8;
  localparam int unsigned BCW   = (BW > 1) ? $clog2(BW) : 1;
  localparam int unsigned CW    = $clog2(BURST_LEN + 1);
  localparam int unsigned CMASK = (32'd1 << CELL_LOG2) - 32'd1;

  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

  state_t          state_q, state_n;
  logic [XW-1:0]   x_q, x_n;
  logic [YW-1:0]   y_q, y_n;
  logic [CW-1:0]   bcnt_q, bcnt_n;
  logic [BCW-1:0]  barc_q, barc_n;
  logic [2:0]      bari_q, bari_n;
  logic [31:0]     adr_q, adr_n;
  logic [31:0]     dat_q, dat_n;
  logic            cyc_q, cyc_n;
  logic            busy_q, busy_n;
  logic            done_q, done_n;
  logic            fin_q, fin_n;
  logic [1:0]      mode_q, mode_n;
  logic [23:0]     fg_q, fg_n;
  logic [23:0]     bg_q, bg_n;
  logic            start;
  logic            x_last;
  logic            frame_last;

  // Colour of pixel (x,y); bar index comes from the running bar counter.
  function automatic logic [23:0] pixel(input logic [1:0] m, input logic [23:0] fg,
                                        input logic [23:0] bg, input int unsigned xi,
                                        input int unsigned yi, input logic [2:0] bi);
    logic [23:0] c;
    c = fg;
    case (m)
      2'd0: if (((xi & CMASK) != 32'd0) && ((yi & CMASK) != 32'd0)) c = bg;
      2'd1: if ((((xi ^ yi) >> CELL_LOG2) & 32'd1) != 32'd0) c = bg;
      2'd2: begin
        case (bi)
          3'd0:    c = 24'hFFFFFF;
          3'd1:    c = 24'hFFFF00;
          3'd2:    c = 24'h00FFFF;
          3'd3:    c = 24'h00FF00;
          3'd4:    c = 24'hFF00FF;
          3'd5:    c = 24'hFF0000;
          3'd6:    c = 24'h0000FF;
          default: c = 24'h000000;
        endcase
      end
      default: c = fg;
    endcase
    return c;
  endfunction

  // Next-state, pixel walk and next-word computation.
  always_comb begin
    state_n    = state_q;
    x_n        = x_q;
    y_n        = y_q;
    bcnt_n     = bcnt_q;
    barc_n     = barc_q;
    bari_n     = bari_q;
    adr_n      = adr_q;
    dat_n      = dat_q;
    cyc_n      = cyc_q;
    busy_n     = busy_q;
    done_n     = 1'b0;
    fin_n      = fin_q;
    mode_n     = mode_q;
    fg_n       = fg_q;
    bg_n       = bg_q;
    start      = 1'b0;
    x_last     = (x_q == XW'(HDISP - 1));
    frame_last = x_last && (y_q == YW'(VDISP - 1));

    case (state_q)
      IDLE: start = enable;
      WRITE: begin
        if (cyc_q && wshb.ack) begin
          if (frame_last) begin
            state_n = GAP;
            cyc_n   = 1'b0;
            bcnt_n  = '0;
            fin_n   = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            adr_n = adr_q + 32'd4;
            if (x_last) begin
              x_n    = '0;
              y_n    = y_q + YW'(1);
              barc_n = '0;
              bari_n = '0;
            end else begin
              x_n = x_q + XW'(1);
              if (barc_q == BCW'(BW - 1)) begin
                barc_n = '0;
                bari_n = bari_q + 3'd1;
              end else begin
                barc_n = barc_q + BCW'(1);
              end
            end
            dat_n = {8'h00, pixel(mode_q, fg_q, bg_q, 32'(x_n), 32'(y_n), bari_n)};
            if (bcnt_q == CW'(BURST_LEN - 1)) begin
              state_n = GAP;
              cyc_n   = 1'b0;
              bcnt_n  = '0;
            end else begin
              bcnt_n = bcnt_q + CW'(1);
            end
          end
        end
      end
      GAP: begin
        if (fin_q) begin
          if (enable) begin
            start = 1'b1;
          end else begin
            state_n = IDLE;
            fin_n   = 1'b0;
          end
        end else begin
          state_n = WRITE;
          cyc_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (start) begin
      state_n = WRITE;
      mode_n  = mode;
      fg_n    = color_fg;
      bg_n    = color_bg;
      x_n     = '0;
      y_n     = '0;
      bcnt_n  = '0;
      barc_n  = '0;
      bari_n  = '0;
      adr_n   = BASE_ADR;
      dat_n   = {8'h00, pixel(mode, color_fg, color_bg, 32'd0, 32'd0, 3'd0)};
      cyc_n   = 1'b1;
      busy_n  = 1'b1;
      fin_n   = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      bcnt_q  <= '0;
      barc_q  <= '0;
      bari_q  <= '0;
      adr_q   <= BASE_ADR;
      dat_q   <= '0;
      cyc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fin_q   <= 1'b0;
      mode_q  <= '0;
      fg_q    <= '0;
      bg_q    <= '0;
    end else begin
      state_q <= state_n;
      x_q     <= x_n;
      y_q     <= y_n;
      bcnt_q  <= bcnt_n;
      barc_q  <= barc_n;
      bari_q  <= bari_n;
      adr_q   <= adr_n;
      dat_q   <= dat_n;
      cyc_q   <= cyc_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      fin_q   <= fin_n;
      mode_q  <= mode_n;
      fg_q    <= fg_n;
      bg_q    <= bg_n;
    end
  end

  assign wshb.adr    = adr_q;
  assign wshb.dat_ms = dat_q;
  assign wshb.we     = 1'b1;
  assign wshb.sel    = 4'b1111;
  assign wshb.cti    = 3'b000;
  assign wshb.bte    = 2'b00;
  assign wshb.cyc    = cyc_q;
  assign wshb.stb    = cyc_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_mire_multi.sv
// Directed bench for mire_multi: grid/checker/solid image, wait states, bursts, continuous, reset, bars.
module tb_mire_multi;

  localparam int unsigned AH = 32;
  localparam int unsigned AV = 4;
  localparam int unsigned AN = AH * AV;
  localparam logic [31:0] ABASE = 32'h100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, a_en, b_en;
  logic [1:0]  a_mode, b_mode;
  logic [23:0] a_fg, a_bg, b_fg, b_bg;
  logic        a_busy, a_done, b_busy, b_done;

  mire_multi_if a_bus();
  mire_multi_if b_bus();

  mire_multi #(.HDISP(AH), .VDISP(AV), .BASE_ADR(ABASE), .CELL_LOG2(2), .BURST_LEN(8)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(a_en), .mode(a_mode), .color_fg(a_fg), .color_bg(a_bg),
    .wshb(a_bus), .busy(a_busy), .frame_done(a_done));

  mire_multi #(.HDISP(16), .VDISP(1), .BASE_ADR(32'h0), .CELL_LOG2(2), .BURST_LEN(64)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(b_en), .mode(b_mode), .color_fg(b_fg), .color_bg(b_bg),
    .wshb(b_bus), .busy(b_busy), .frame_done(b_done));

  int n_assert = 0;
  int n_fail   = 0;

  // Bus monitor state for DUT A (cumulative; tests work on deltas).
  logic [31:0] img [AN];
  logic [31:0] alog [2048];
  int acks = 0, falls = 0, gap1 = 0, burst_err = 0, stab_err = 0, fd_cnt = 0;
  int words_in_burst = 0, low_run = 100, cycle = 0, t_last = 0, t_restart = -100, a_idx;
  logic prev_pend = 1'b0, prev_cyc = 1'b0;
  logic [31:0] prev_adr = '0, prev_dat = '0;

  always @(negedge clk) begin
    cycle++;
    if (a_done) fd_cnt++;
    if (prev_pend && (a_bus.adr !== prev_adr || a_bus.dat_ms !== prev_dat || a_bus.stb !== 1'b1))
      stab_err++;
    prev_pend = a_bus.stb && !a_bus.ack;
    prev_adr  = a_bus.adr;
    prev_dat  = a_bus.dat_ms;
    if (prev_cyc && !a_bus.cyc) begin
      falls++;
      if (words_in_burst != 8) burst_err++;
      words_in_burst = 0;
    end
    if (!prev_cyc && a_bus.cyc && low_run == 1) begin
      gap1++;
      if (a_bus.adr == ABASE) t_restart = cycle;
    end
    if (a_bus.cyc) low_run = 0; else low_run++;
    if (a_bus.cyc && a_bus.stb && a_bus.ack) begin
      a_idx = int'((a_bus.adr - ABASE) >> 2);
      if (a_idx >= 0 && a_idx < int'(AN)) img[a_idx] = a_bus.dat_ms;
      if (acks < 2048) alog[acks] = a_bus.adr;
      if (a_bus.adr == ABASE + 32'h1FC) t_last = cycle;
      acks++;
      words_in_burst++;
    end
    prev_cyc = a_bus.cyc;
  end

  // Bus monitor for DUT B.
  logic [31:0] bimg [16];
  int b_acks = 0, b_fd = 0;
  always @(negedge clk) begin
    if (b_done) b_fd++;
    if (b_bus.cyc && b_bus.stb && b_bus.ack) begin
      bimg[b_bus.adr[5:2]] = b_bus.dat_ms;
      b_acks++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drive ack (optionally with random stalls) until nfr more frames complete.
  task automatic run_a(input int stall_max, input int nfr, input int budget, input string tag);
    int target;
    int stall;
    int n;
    target = fd_cnt + nfr;
    stall = 0;
    n = 0;
    while (fd_cnt < target && n < budget) begin
      @(posedge clk); #1;
      if (stall_max == 0) a_bus.ack = 1'b1;
      else if (a_bus.stb && stall > 0) begin a_bus.ack = 1'b0; stall--; end
      else begin a_bus.ack = 1'b1; stall = int'($urandom_range(stall_max, 0)); end
      n++;
    end
    a_bus.ack = 1'b1;
    chk({tag, "_timeout"}, 32'(fd_cnt >= target), 32'd1);
  endtask

  task automatic start_a();
    a_en = 1'b1;
    step(1);
    a_en = 1'b0;
  endtask

  function automatic logic [31:0] exp_px(input logic [1:0] m, input logic [23:0] fg,
                                         input logic [23:0] bg, input int x, input int y);
    case (m)
      2'd0:    return {8'h00, ((x % 4 == 0) || (y % 4 == 0)) ? fg : bg};
      2'd1:    return {8'h00, (((x / 4) + (y / 4)) % 2 == 0) ? fg : bg};
      default: return {8'h00, fg};
    endcase
  endfunction

  function automatic int img_bad(input logic [1:0] m, input logic [23:0] fg, input logic [23:0] bg);
    int bad;
    bad = 0;
    for (int i = 0; i < int'(AN); i++)
      if (img[i] !== exp_px(m, fg, bg, i % int'(AH), i / int'(AH))) bad++;
    return bad;
  endfunction

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  logic [31:0] gold [AN];

  initial begin
    int acks0, falls0, gap10, berr0, stab0, fd0, bfd0, bad, n;
    rst_n = 1'b0; a_en = 1'b0; b_en = 1'b0;
    a_mode = 2'd0; a_fg = 24'hFF0000; a_bg = 24'h0000FF;
    b_mode = 2'd2; b_fg = 24'h123456; b_bg = 24'h654321;
    a_bus.ack = 1'b1; b_bus.ack = 1'b1;
    step(3);
    chk("rst_cyc", 32'(a_bus.cyc), 32'd0);
    chk("rst_stb", 32'(a_bus.stb), 32'd0);
    chk("rst_adr", a_bus.adr, ABASE);
    chk("rst_dat", a_bus.dat_ms, 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    rst_n = 1'b1;
    step(2);

    // Grid, zero wait states, burst release every 8 words
    acks0 = acks; falls0 = falls; gap10 = gap1; berr0 = burst_err; fd0 = fd_cnt;
    start_a();
    chk("first_stb", 32'(a_bus.stb), 32'd1);
    chk("first_adr", a_bus.adr, ABASE);
    chk("first_dat", a_bus.dat_ms, 32'h00FF0000);
    chk("first_busy", 32'(a_busy), 32'd1);
    run_a(0, 1, 2000, "grid");
    step(4);
    chk("grid_acks", 32'(acks - acks0), 32'd128);
    chk("grid_last_adr", alog[acks0 + 127], ABASE + 32'h1FC);
    chk("grid_9th_adr", alog[acks0 + 8], ABASE + 32'h20);
    chk("grid_0_1", img[32], 32'h00FF0000);
    chk("grid_1_1", img[33], 32'h000000FF);
    chk("grid_4_1", img[36], 32'h00FF0000);
    chk("grid_5_0", img[5], 32'h00FF0000);
    chk("grid_image", 32'(img_bad(2'd0, a_fg, a_bg)), 32'd0);
    chk("grid_falls", 32'(falls - falls0), 32'd16);
    chk("grid_gaps", 32'(gap1 - gap10), 32'd15);
    chk("grid_burst", 32'(burst_err - berr0), 32'd0);
    chk("grid_done_pulses", 32'(fd_cnt - fd0), 32'd1);
    chk("grid_idle_cyc", 32'(a_bus.cyc), 32'd0);
    chk("grid_idle_busy", 32'(a_busy), 32'd0);
    for (int i = 0; i < int'(AN); i++) gold[i] = img[i];

    // Same frame with random 0-5 cycle ack stalls
    acks0 = acks; stab0 = stab_err;
    start_a();
    run_a(5, 1, 6000, "wait");
    step(2);
    chk("wait_acks", 32'(acks - acks0), 32'd128);
    chk("wait_stable", 32'(stab_err - stab0), 32'd0);
    bad = 0;
    for (int i = 0; i < int'(AN); i++) if (img[i] !== gold[i]) bad++;
    chk("wait_image", 32'(bad), 32'd0);

    // Checkerboard
    a_mode = 2'd1; a_fg = 24'h00FF00; a_bg = 24'h123456;
    start_a();
    run_a(0, 1, 2000, "chk");
    step(2);
    chk("chk_0_0", img[0], 32'h0000FF00);
    chk("chk_4_1", img[36], 32'h00123456);
    chk("chk_8_3", img[104], 32'h0000FF00);
    chk("chk_image", 32'(img_bad(2'd1, a_fg, a_bg)), 32'd0);

    // Solid
    a_mode = 2'd3;
    start_a();
    run_a(0, 1, 2000, "solid");
    step(2);
    chk("solid_image", 32'(img_bad(2'd3, a_fg, a_bg)), 32'd0);

    // Continuous: two frames with enable high, drop it during frame 3
    acks0 = acks; fd0 = fd_cnt;
    a_en = 1'b1;
    run_a(0, 2, 4000, "cont");
    step(2);
    chk("cont_restart_gap", 32'(t_restart - t_last), 32'd2);
    step(20);
    a_en = 1'b0;
    run_a(0, 1, 4000, "cont3");
    step(10);
    chk("cont_done_pulses", 32'(fd_cnt - fd0), 32'd3);
    chk("cont_acks", 32'(acks - acks0), 32'd384);
    chk("cont_idle_cyc", 32'(a_bus.cyc), 32'd0);
    chk("cont_idle_busy", 32'(a_busy), 32'd0);

    // Reset in the middle of a burst with ack held high
    start_a();
    step(5);
    chk("pre_rst_cyc", 32'(a_bus.cyc), 32'd1);
    rst_n = 1'b0;
    step(1);
    chk("midrst_cyc", 32'(a_bus.cyc), 32'd0);
    chk("midrst_stb", 32'(a_bus.stb), 32'd0);
    chk("midrst_adr", a_bus.adr, ABASE);
    chk("midrst_busy", 32'(a_busy), 32'd0);
    rst_n = 1'b1;
    acks0 = acks;
    start_a();
    chk("restart_stb", 32'(a_bus.stb), 32'd1);
    chk("restart_adr", a_bus.adr, ABASE);
    chk("restart_dat", a_bus.dat_ms, 32'h0000FF00);
    run_a(0, 1, 2000, "restart");
    step(2);
    chk("restart_acks", 32'(acks - acks0), 32'd128);

    // Colour bars on the 16x1 instance
    bfd0 = b_fd;
    b_en = 1'b1;
    step(1);
    b_en = 1'b0;
    n = 0;
    while (b_fd == bfd0 && n < 500) begin step(1); n++; end
    chk("bars_timeout", 32'(b_fd != bfd0), 32'd1);
    chk("bars_acks", 32'(b_acks), 32'd16);
    for (int i = 0; i < 16; i++) chk($sformatf("bars_w%0d", i), bimg[i], {8'h00, bars[i / 2]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
